// File: rtl/cas_pkg.sv
// Shared types and constants for the cassette FSK playback engine.
package cas_pkg;

  localparam int ADDR_W    = 25;
  // CoCo FSK half-periods at 50 MHz: 1200 Hz for a 0-bit, 2400 Hz for a 1-bit
  localparam int HALF0_50M = 20833;
  localparam int HALF1_50M = 10417;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    PLAY,
    EOT
  } state_t;

endpackage

// File: rtl/cas_halfcycle_timer.sv
// Loadable down-counter with a pause enable and a one-cycle done pulse.
// done fires in the cycle the count sits at zero; a load in that same
// cycle rearms the timer so back-to-back periods have no gap.
module cas_halfcycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;
  logic         busy;

  assign done = busy && en && (cnt == '0);

  // count down while armed and enabled; load wins over expiry
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      busy <= 1'b1;
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy && en) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/cas_fsk_player.sv
// Cassette playback: fetches .CAS bytes from SDRAM and plays them LSB-first
// as CoCo FSK (one 1200 Hz cycle per 0-bit, one 2400 Hz cycle per 1-bit).
// The next byte is prefetched during bit 0 so consecutive bytes are gapless.
module cas_fsk_player
  import cas_pkg::*;
#(
  parameter int HALF0  = HALF0_50M,
  parameter int HALF1  = HALF1_50M,
  parameter int RD_LAT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              rewind,
  input  logic [ADDR_W-1:0] tape_len,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_rd,
  input  logic [7:0]        sdram_data,
  output logic              data,
  output logic              eot
);

  localparam int CW = $clog2(HALF0 + 1);
  localparam int LW = $clog2(RD_LAT + 1);

  state_t        state, state_nxt;
  logic [7:0]    shreg, nxt, src_byte;
  logic          nxt_v, first;
  logic [2:0]    bit_idx;
  logic          rd, lat_load, lat_done;
  logic          half_load, half_done, half_en;
  logic [CW-1:0] half_val;
  logic          start, use_nxt, cap_nxt, hi_to_lo, next_bit;

  // timer reload value for a bit's half-period
  function automatic logic [CW-1:0] half_of(input logic b);
    return b ? CW'(HALF1 - 1) : CW'(HALF0 - 1);
  endfunction

  assign half_en  = (state == PLAY) && en;
  assign sdram_rd = rd && !rewind;
  assign eot      = (state == EOT);
  assign src_byte = use_nxt ? nxt : sdram_data;

  cas_halfcycle_timer #(.W(CW)) u_half (
    .clk      (clk),
    .reset    (reset),
    .clr      (rewind),
    .en       (half_en),
    .load     (half_load),
    .load_val (half_val),
    .done     (half_done)
  );

  // the SDRAM never pauses, so the read-latency timer always runs
  cas_halfcycle_timer #(.W(LW)) u_lat (
    .clk      (clk),
    .reset    (reset),
    .clr      (rewind),
    .en       (1'b1),
    .load     (lat_load),
    .load_val (LW'(RD_LAT)),
    .done     (lat_done)
  );

  // state register; rewind parks the engine in IDLE for as long as it is held
  always_ff @(posedge clk) begin
    if (reset || rewind) state <= IDLE;
    else                 state <= state_nxt;
  end

  // next state, strobes and datapath controls
  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    lat_load  = 1'b0;
    half_load = 1'b0;
    half_val  = half_of(1'b0);
    start     = 1'b0;
    use_nxt   = 1'b0;
    cap_nxt   = 1'b0;
    hi_to_lo  = 1'b0;
    next_bit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (sdram_addr >= tape_len) state_nxt = EOT;
        else if (en)                state_nxt = FETCH;
      end
      FETCH: begin
        rd        = 1'b1;
        lat_load  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // a read landing while paused is parked in nxt until en returns
        if (en && (lat_done || nxt_v)) begin
          start     = 1'b1;
          use_nxt   = !lat_done;
          state_nxt = PLAY;
        end else if (lat_done) begin
          cap_nxt = 1'b1;
        end
      end
      PLAY: begin
        cap_nxt = lat_done;
        if (en && first && (sdram_addr < tape_len)) begin
          rd       = 1'b1;
          lat_load = 1'b1;
        end
        if (half_done) begin
          if (data) begin
            hi_to_lo  = 1'b1;
            half_load = 1'b1;
            half_val  = half_of(shreg[bit_idx]);
          end else if (bit_idx != 3'd7) begin
            next_bit  = 1'b1;
            half_load = 1'b1;
            half_val  = half_of(shreg[bit_idx + 3'd1]);
          end else if (nxt_v) begin
            start   = 1'b1;
            use_nxt = 1'b1;
          end else begin
            state_nxt = EOT;
          end
        end
      end
      EOT: ;
      default: state_nxt = IDLE;
    endcase
    if (start) begin
      half_load = 1'b1;
      half_val  = half_of(src_byte[0]);
    end
  end

  // address, shift register, prefetch buffer and the FSK output level
  always_ff @(posedge clk) begin
    if (reset) begin
      sdram_addr <= '0;
      nxt_v      <= 1'b0;
      nxt        <= '0;
      shreg      <= '0;
      bit_idx    <= '0;
      first      <= 1'b0;
      data       <= 1'b0;
    end else if (rewind) begin
      sdram_addr <= '0;
      nxt_v      <= 1'b0;
      bit_idx    <= '0;
      first      <= 1'b0;
      data       <= 1'b0;
    end else begin
      if (state == PLAY && en) first <= 1'b0;
      if (cap_nxt) begin
        nxt        <= sdram_data;
        nxt_v      <= 1'b1;
        sdram_addr <= sdram_addr + ADDR_W'(1);
      end
      if (start) begin
        shreg   <= src_byte;
        bit_idx <= '0;
        data    <= 1'b1;
        first   <= 1'b1;
        if (use_nxt) nxt_v      <= 1'b0;
        else         sdram_addr <= sdram_addr + ADDR_W'(1);
      end
      if (hi_to_lo) data <= 1'b0;
      if (next_bit) begin
        bit_idx <= bit_idx + 3'd1;
        data    <= 1'b1;
      end
      if (state_nxt == EOT) data <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cas_fsk_player.sv
// Directed bench for cas_fsk_player with HALF0=4, HALF1=2, RD_LAT=3.
module tb_cas_fsk_player;

  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        reset, en, rewind;
  logic [24:0] tape_len;
  logic [24:0] sdram_addr;
  logic        sdram_rd;
  logic [7:0]  sdram_data = 8'h00;
  logic        data, eot;

  logic [7:0]  mem [16];
  logic [3:0]  m_addr = '0;
  int          m_cnt = 0;
  bit          m_pend = 0;

  int   checks = 0;
  int   failures = 0;
  logic exp_q[$];

  cas_fsk_player #(.HALF0(4), .HALF1(2), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .rewind     (rewind),
    .tape_len   (tape_len),
    .sdram_addr (sdram_addr),
    .sdram_rd   (sdram_rd),
    .sdram_data (sdram_data),
    .data       (data),
    .eot        (eot)
  );

  always #5 clk = ~clk;

  // SDRAM model: data turns to junk when a strobe is seen and the real byte
  // is valid from RD_LAT cycles after the strobe cycle, then held
  always @(posedge clk) begin
    if (sdram_rd) begin
      m_addr     <= sdram_addr[3:0];
      m_cnt      <= RD_LAT - 1;
      m_pend     <= 1'b1;
      sdram_data <= 8'h5A;
    end else if (m_pend) begin
      if (m_cnt == 1) begin
        sdram_data <= mem[m_addr];
        m_pend     <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // reference FSK waveform of one byte, one sample per clk
  task automatic add_byte(input logic [7:0] b);
    int h;
    for (int i = 0; i < 8; i++) begin
      h = b[i] ? 2 : 4;
      for (int j = 0; j < h; j++) exp_q.push_back(1'b1);
      for (int j = 0; j < h; j++) exp_q.push_back(1'b0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; rewind = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    mem[0] = 8'h55; tape_len = 25'd4;
    reset = 1'b1; en = 1'b1; rewind = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sdram_addr !== 25'd0) begin failures++; $display("FAIL reset_addr: got %0h expected 0", sdram_addr); end
    checks++; if (sdram_rd !== 1'b0) begin failures++; $display("FAIL reset_rd: got %b expected 0", sdram_rd); end
    checks++; if (data !== 1'b0) begin failures++; $display("FAIL reset_data: got %b expected 0", data); end
    checks++; if (eot !== 1'b0) begin failures++; $display("FAIL reset_eot: got %b expected 0", eot); end
    reset = 1'b0; en = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({sdram_rd, data, eot, sdram_addr} !== 28'd0) begin
      failures++; $display("FAIL idle_no_en: got rd/data/eot=%b%b%b addr=%0h expected all 0", sdram_rd, data, eot, sdram_addr);
    end
  endtask

  task automatic test_single_byte();
    bit bad; int bi; logic bo;
    mem[0] = 8'h01; tape_len = 25'd1;
    do_reset();
    exp_q.delete(); add_byte(8'h01);
    en = 1'b1;
    @(negedge clk);
    checks++; if (sdram_rd !== 1'b1) begin failures++; $display("FAIL single_fetch_rd: got %b expected 1", sdram_rd); end
    repeat (4) @(negedge clk);
    checks++; if (data !== 1'b0) begin failures++; $display("FAIL single_pre_data: got %b expected 0", data); end
    bad = 0; bi = 0; bo = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (!bad && (data !== exp_q[i] || eot !== 1'b0)) begin bad = 1; bi = i; bo = data; end
    end
    checks++; if (bad) begin failures++; $display("FAIL single_wave: cycle %0d got %b expected %b", bi, bo, exp_q[bi]); end
    @(negedge clk);
    checks++; if (eot !== 1'b1) begin failures++; $display("FAIL single_eot: got %b expected 1", eot); end
    checks++; if (sdram_addr !== 25'd1) begin failures++; $display("FAIL single_addr: got %0h expected 1", sdram_addr); end
    checks++; if (data !== 1'b0) begin failures++; $display("FAIL single_eot_data: got %b expected 0", data); end
  endtask

  task automatic test_two_bytes();
    bit bad; int bi; logic bo; int n0, n1; logic rd_first;
    mem[0] = 8'hFF; mem[1] = 8'h00; tape_len = 25'd2;
    do_reset();
    exp_q.delete(); add_byte(8'hFF); add_byte(8'h00);
    en = 1'b1;
    repeat (5) @(negedge clk);
    bad = 0; bi = 0; bo = 0; n0 = 0; n1 = 0; rd_first = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) rd_first = sdram_rd;
      if (sdram_rd) begin if (i < 32) n0++; else n1++; end
      if (!bad && data !== exp_q[i]) begin bad = 1; bi = i; bo = data; end
    end
    checks++; if (bad) begin failures++; $display("FAIL two_wave: cycle %0d got %b expected %b", bi, bo, exp_q[bi]); end
    checks++; if (rd_first !== 1'b1) begin failures++; $display("FAIL two_prefetch_first: got %b expected 1", rd_first); end
    checks++; if (n0 != 1) begin failures++; $display("FAIL two_rd_byte0: got %0d expected 1", n0); end
    checks++; if (n1 != 0) begin failures++; $display("FAIL two_rd_byte1: got %0d expected 0", n1); end
    @(negedge clk);
    checks++; if (eot !== 1'b1) begin failures++; $display("FAIL two_eot: got %b expected 1", eot); end
    checks++; if (sdram_addr !== 25'd2) begin failures++; $display("FAIL two_addr: got %0h expected 2", sdram_addr); end
  endtask

  task automatic test_pause();
    bit bad; int bi; logic bo, be, ev; int len;
    mem[0] = 8'h96; mem[1] = 8'h3C; tape_len = 25'd2;
    do_reset();
    exp_q.delete(); add_byte(8'h96); add_byte(8'h3C);
    len = exp_q.size();
    en = 1'b1;
    repeat (5) @(negedge clk);
    bad = 0; bi = 0; bo = 0; be = 0;
    for (int t = 0; t < len + 10; t++) begin
      @(negedge clk);
      ev = (t <= 1) ? exp_q[t] : (t <= 11) ? exp_q[1] : exp_q[t - 10];
      if (!bad && data !== ev) begin bad = 1; bi = t; bo = data; be = ev; end
      if (t == 8) begin
        checks++; if (sdram_addr !== 25'd2) begin failures++; $display("FAIL pause_prefetch_addr: got %0h expected 2", sdram_addr); end
      end
      if (t == 1) en = 1'b0;
      if (t == 11) en = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL pause_wave: cycle %0d got %b expected %b", bi, bo, be); end
    @(negedge clk);
    checks++; if (eot !== 1'b1) begin failures++; $display("FAIL pause_eot: got %b expected 1", eot); end
  endtask

  task automatic test_rewind();
    bit bad; int bi; logic bo;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; tape_len = 25'd3;
    do_reset();
    exp_q.delete(); add_byte(8'h11); add_byte(8'h22);
    en = 1'b1;
    repeat (82) @(negedge clk);
    checks++; if (sdram_addr !== 25'd3) begin failures++; $display("FAIL rew_pre_addr: got %0h expected 3", sdram_addr); end
    rewind = 1'b1;
    @(negedge clk);
    checks++; if (sdram_addr !== 25'd0) begin failures++; $display("FAIL rew_addr: got %0h expected 0", sdram_addr); end
    checks++; if (data !== 1'b0) begin failures++; $display("FAIL rew_data: got %b expected 0", data); end
    checks++; if (eot !== 1'b0) begin failures++; $display("FAIL rew_eot: got %b expected 0", eot); end
    @(negedge clk);
    checks++; if ({sdram_rd, data} !== 2'b00) begin failures++; $display("FAIL rew_hold: got rd/data=%b%b expected 00", sdram_rd, data); end
    rewind = 1'b0;
    @(negedge clk);
    checks++; if (sdram_rd !== 1'b1) begin failures++; $display("FAIL rew_refetch: got %b expected 1", sdram_rd); end
    repeat (4) @(negedge clk);
    bad = 0; bi = 0; bo = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (!bad && data !== exp_q[i]) begin bad = 1; bi = i; bo = data; end
    end
    checks++; if (bad) begin failures++; $display("FAIL rew_replay_wave: cycle %0d got %b expected %b", bi, bo, exp_q[bi]); end
  endtask

  task automatic test_tape_len_zero();
    int n; bit bad;
    tape_len = 25'd0;
    do_reset();
    en = 1'b1;
    @(negedge clk);
    checks++; if (eot !== 1'b1) begin failures++; $display("FAIL zero_eot: got %b expected 1", eot); end
    n = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sdram_rd) n++;
      if (eot !== 1'b1 || data !== 1'b0) bad = 1;
    end
    checks++; if (n != 0) begin failures++; $display("FAIL zero_no_rd: got %0d strobes expected 0", n); end
    checks++; if (bad) begin failures++; $display("FAIL zero_eot_hold: got eot/data=%b%b expected 10", eot, data); end
  endtask

  task automatic test_reset_in_wait();
    bit bad;
    mem[0] = 8'hA5; tape_len = 25'd1;
    do_reset();
    en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({sdram_rd, data, eot, sdram_addr} !== 28'd0) begin
      failures++; $display("FAIL wait_reset_out: got rd/data/eot=%b%b%b addr=%0h expected all 0", sdram_rd, data, eot, sdram_addr);
    end
    reset = 1'b0; en = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sdram_addr !== 25'd0 || data !== 1'b0 || sdram_rd !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin failures++; $display("FAIL wait_late_data: got addr=%0h data=%b expected 0/0", sdram_addr, data); end
    en = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (data !== 1'b0) begin failures++; $display("FAIL wait_restart_pre: got %b expected 0", data); end
    @(negedge clk);
    checks++; if (data !== 1'b1) begin failures++; $display("FAIL wait_restart_hi: got %b expected 1", data); end
    checks++; if (sdram_addr !== 25'd1) begin failures++; $display("FAIL wait_restart_addr: got %0h expected 1", sdram_addr); end
    repeat (2) @(negedge clk);
    checks++; if (data !== 1'b0) begin failures++; $display("FAIL wait_restart_bit0: got %b expected 0", data); end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; rewind = 1'b0; tape_len = 25'd0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_single_byte();
    test_two_bytes();
    test_pause();
    test_rewind();
    test_tape_len_zero();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
